// File: rtl/regfile_ckpt_pkg.sv
// Shared constants and status-entry type for the register file with rename checkpoints.
package rf_pkg;

  localparam int XLEN      = 32;
  localparam int REG_IDX_W = 5;
  localparam int ROB_W     = 4;
  localparam int NUM_REGS  = 32;
  localparam int STAT_W    = 1 + ROB_W;

  typedef struct packed {
    logic             dirty;
    logic [ROB_W-1:0] tag;
  } status_t;

endpackage

// File: rtl/regfile_ckpt_slot.sv
// One checkpoint slot: a full 32-entry rename-status snapshot.
// Loaded on a take; otherwise tracks commits so a later restore sees retired producers as clean.
module rf_ckpt_slot #(
  parameter int ROB_W = rf_pkg::ROB_W
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               load,
  input  logic [rf_pkg::NUM_REGS-1:0]        load_dirty,
  input  logic [rf_pkg::NUM_REGS*ROB_W-1:0]  load_tag,
  input  logic                               clr_valid,
  input  logic [rf_pkg::REG_IDX_W-1:0]       clr_rd,
  input  logic [ROB_W-1:0]                   clr_tag,
  output logic [rf_pkg::NUM_REGS-1:0]        dirty,
  output logic [rf_pkg::NUM_REGS*ROB_W-1:0]  tag
);
  import rf_pkg::*;

  logic [NUM_REGS-1:0]            dirty_q, dirty_d;
  logic [NUM_REGS-1:0][ROB_W-1:0] tag_q, tag_d;

  assign dirty = dirty_q;
  assign tag   = tag_q;

  // Snapshot load wins; otherwise clear the entry whose producer is committing now.
  always_comb begin
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (load) begin
      dirty_d = load_dirty;
      tag_d   = load_tag;
    end else if (clr_valid && (clr_rd != '0) && dirty_q[clr_rd] && (tag_q[clr_rd] == clr_tag)) begin
      dirty_d[clr_rd] = 1'b0;
      tag_d[clr_rd]   = '0;
    end
  end

  // Snapshot storage; contents only matter while the slot is in use, but reset keeps them defined.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dirty_q <= '0;
      tag_q   <= '0;
    end else begin
      dirty_q <= dirty_d;
      tag_q   <= tag_d;
    end
  end

endmodule

// File: rtl/regfile_ckpt.sv
// Architectural register file with rename-status table and branch checkpoints of that table.
// Decoder reads/renames, ROB commit writes, branch unit takes/restores/releases snapshots.
module regfile_ckpt #(
  parameter int XLEN     = rf_pkg::XLEN,
  parameter int ROB_W    = rf_pkg::ROB_W,
  parameter int NUM_RD   = 2,
  parameter int CKPT_NUM = 4,
  localparam int CK_W    = $clog2(CKPT_NUM)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    rdy,
  input  logic [NUM_RD*5-1:0]     rd_idx,
  output logic [NUM_RD-1:0]       rd_dirty,
  output logic [NUM_RD*ROB_W-1:0] rd_tag,
  output logic [NUM_RD*XLEN-1:0]  rd_val,
  input  logic                    cm_valid,
  input  logic [4:0]              cm_rd,
  input  logic [ROB_W-1:0]        cm_tag,
  input  logic [XLEN-1:0]         cm_val,
  input  logic                    ds_valid,
  input  logic [4:0]              ds_rd,
  input  logic [ROB_W-1:0]        ds_tag,
  input  logic                    ck_take,
  output logic [CK_W-1:0]         ck_id,
  output logic                    ck_full,
  input  logic                    ck_restore,
  input  logic [CK_W-1:0]         ck_restore_id,
  input  logic                    ck_release,
  input  logic                    flush
);
  import rf_pkg::*;

  localparam int               CNT_W    = CK_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CKPT_NUM);

  logic [NUM_REGS-1:0][XLEN-1:0]  val_q, val_d;
  logic [NUM_REGS-1:0]            dirty_q, dirty_d;
  logic [NUM_REGS-1:0][ROB_W-1:0] tag_q, tag_d;
  logic [CK_W-1:0]                head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]               count_q, count_d;
  logic                           ck_full_q, ck_full_d;

  logic [NUM_REGS-1:0]            slot_dirty [CKPT_NUM];
  logic [NUM_REGS*ROB_W-1:0]      slot_tag   [CKPT_NUM];
  logic [NUM_REGS-1:0]            rs_dirty;
  logic [NUM_REGS-1:0][ROB_W-1:0] rs_tag;
  logic [CK_W-1:0]                restore_ofs;

  logic cm_en, cm_hit, ds_en, take_en, rel_en, restore_en, flush_en;

  assign flush_en    = rdy && flush;
  assign restore_en  = rdy && ck_restore && !flush;
  assign cm_en       = rdy && cm_valid && (cm_rd != '0);
  assign cm_hit      = cm_en && dirty_q[cm_rd] && (tag_q[cm_rd] == cm_tag);
  assign ds_en       = rdy && ds_valid && (ds_rd != '0) && !ck_restore && !flush;
  assign take_en     = rdy && ck_take && !ck_full_q && !ck_restore && !flush;
  assign rel_en      = rdy && ck_release && (count_q != '0) && !flush;
  assign rs_dirty    = slot_dirty[ck_restore_id];
  assign rs_tag      = slot_tag[ck_restore_id];
  assign restore_ofs = ck_restore_id - head_q;

  assign ck_id   = tail_q;
  assign ck_full = ck_full_q;

  for (genvar s = 0; s < CKPT_NUM; s++) begin : g_slot
    rf_ckpt_slot #(.ROB_W(ROB_W)) u_slot (
      .clk        (clk),
      .rst        (rst),
      .load       (take_en && (tail_q == CK_W'(s))),
      .load_dirty (dirty_d),
      .load_tag   (tag_d),
      .clr_valid  (cm_en),
      .clr_rd     (cm_rd),
      .clr_tag    (cm_tag),
      .dirty      (slot_dirty[s]),
      .tag        (slot_tag[s])
    );
  end

  // Next live values and status: flush beats restore beats normal commit-clear/rename.
  always_comb begin
    val_d   = val_q;
    dirty_d = dirty_q;
    tag_d   = tag_q;
    if (cm_en) begin
      val_d[cm_rd] = cm_val;
    end
    if (flush_en) begin
      dirty_d = '0;
      tag_d   = '0;
    end else if (restore_en) begin
      dirty_d = rs_dirty;
      tag_d   = rs_tag;
      if (cm_en && rs_dirty[cm_rd] && (rs_tag[cm_rd] == cm_tag)) begin
        dirty_d[cm_rd] = 1'b0;
        tag_d[cm_rd]   = '0;
      end
    end else begin
      if (cm_hit) begin
        dirty_d[cm_rd] = 1'b0;
        tag_d[cm_rd]   = '0;
      end
      if (ds_en) begin
        dirty_d[ds_rd] = 1'b1;
        tag_d[ds_rd]   = ds_tag;
      end
    end
  end

  // Checkpoint ring pointers; a restore frees its slot and everything younger.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_en) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (rel_en) begin
        head_d = head_q + 1'b1;
      end
      if (restore_en) begin
        tail_d  = ck_restore_id;
        count_d = CNT_W'(CK_W'(ck_restore_id - head_d));
      end else begin
        if (take_en) begin
          tail_d = tail_q + 1'b1;
        end
        count_d = count_q + CNT_W'(take_en) - CNT_W'(rel_en);
      end
    end
    ck_full_d = (count_d == CNT_FULL);
  end

  // Live state registers, frozen whenever rdy is low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      val_q     <= '0;
      dirty_q   <= '0;
      tag_q     <= '0;
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      ck_full_q <= 1'b0;
    end else begin
      val_q     <= val_d;
      dirty_q   <= dirty_d;
      tag_q     <= tag_d;
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      ck_full_q <= ck_full_d;
    end
  end

  // Read ports: x0 is hardwired clean zero, a matching commit is bypassed, renames are not.
  always_comb begin
    rd_dirty = '0;
    rd_tag   = '0;
    rd_val   = '0;
    for (int k = 0; k < NUM_RD; k++) begin
      if (rd_idx[k*5 +: 5] == '0) begin
        rd_dirty[k] = 1'b0;
      end else if (cm_valid && (cm_rd == rd_idx[k*5 +: 5]) && dirty_q[rd_idx[k*5 +: 5]]
                   && (tag_q[rd_idx[k*5 +: 5]] == cm_tag)) begin
        rd_val[k*XLEN +: XLEN] = cm_val;
      end else begin
        rd_dirty[k]              = dirty_q[rd_idx[k*5 +: 5]];
        rd_tag[k*ROB_W +: ROB_W] = tag_q[rd_idx[k*5 +: 5]];
        rd_val[k*XLEN +: XLEN]   = val_q[rd_idx[k*5 +: 5]];
      end
    end
  end

  // A restore must target a slot that is currently holding a live checkpoint.
  restore_in_range: assert property (@(posedge clk) disable iff (!rst)
    (rdy && ck_restore && !flush) |-> (CNT_W'(restore_ofs) < count_q));

endmodule

// File: tb/tb_regfile_ckpt.sv
// Directed bench for regfile_ckpt: reads, bypass, rename ordering, checkpoints, flush, freeze.
module tb_regfile_ckpt;

  localparam int XLEN = 32, ROB_W = 4, NUM_RD = 2, CKPT_NUM = 4, CK_W = 2;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rdy;
  logic [NUM_RD*5-1:0]     rd_idx;
  logic [NUM_RD-1:0]       rd_dirty;
  logic [NUM_RD*ROB_W-1:0] rd_tag;
  logic [NUM_RD*XLEN-1:0]  rd_val;
  logic                    cm_valid;
  logic [4:0]              cm_rd;
  logic [ROB_W-1:0]        cm_tag;
  logic [XLEN-1:0]         cm_val;
  logic                    ds_valid;
  logic [4:0]              ds_rd;
  logic [ROB_W-1:0]        ds_tag;
  logic                    ck_take;
  logic [CK_W-1:0]         ck_id;
  logic                    ck_full;
  logic                    ck_restore;
  logic [CK_W-1:0]         ck_restore_id;
  logic                    ck_release;
  logic                    flush;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  regfile_ckpt #(.XLEN(XLEN), .ROB_W(ROB_W), .NUM_RD(NUM_RD), .CKPT_NUM(CKPT_NUM)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rd_idx(rd_idx), .rd_dirty(rd_dirty), .rd_tag(rd_tag),
    .rd_val(rd_val), .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_tag(cm_tag), .cm_val(cm_val),
    .ds_valid(ds_valid), .ds_rd(ds_rd), .ds_tag(ds_tag), .ck_take(ck_take), .ck_id(ck_id),
    .ck_full(ck_full), .ck_restore(ck_restore), .ck_restore_id(ck_restore_id),
    .ck_release(ck_release), .flush(flush)
  );

  task automatic idle();
    rdy = 1'b1; cm_valid = 1'b0; cm_rd = '0; cm_tag = '0; cm_val = '0;
    ds_valid = 1'b0; ds_rd = '0; ds_tag = '0; ck_take = 1'b0; ck_restore = 1'b0;
    ck_restore_id = '0; ck_release = 1'b0; flush = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
    #1;
  endtask

  task automatic rename(input logic [4:0] r, input logic [3:0] t);
    ds_valid = 1'b1; ds_rd = r; ds_tag = t;
  endtask

  task automatic commit(input logic [4:0] r, input logic [3:0] t, input logic [31:0] v);
    cm_valid = 1'b1; cm_rd = r; cm_tag = t; cm_val = v;
  endtask

  task automatic test_reset();
    rst = 1'b0; idle(); rd_idx = {5'd5, 5'd5};
    #2;
    vectors++; if (rd_dirty !== 2'b00) begin miscompares++; $display("FAIL reset_dirty: got %b want 00", rd_dirty); end
    vectors++; if (rd_tag !== 8'h00) begin miscompares++; $display("FAIL reset_tag: got %h want 00", rd_tag); end
    vectors++; if (rd_val !== 64'h0) begin miscompares++; $display("FAIL reset_val: got %h want 0", rd_val); end
    vectors++; if (ck_full !== 1'b0 || ck_id !== 2'd0) begin miscompares++; $display("FAIL reset_ck: got full %b id %0d want 0 0", ck_full, ck_id); end
    #11 rst = 1'b1;
    tick();
    rd_idx = {5'd0, 5'd0};
    commit(5'd0, 4'd0, 32'hFF);
    #1;
    vectors++; if (rd_val[31:0] !== 32'h0) begin miscompares++; $display("FAIL x0_commit_cycle: got %h want 0", rd_val[31:0]); end
    tick();
    vectors++; if (rd_val[31:0] !== 32'h0 || rd_dirty[0] !== 1'b0) begin miscompares++; $display("FAIL x0_after: got %h/%b want 0/0", rd_val[31:0], rd_dirty[0]); end
  endtask

  task automatic test_bypass();
    rd_idx = {5'd7, 5'd5};
    rename(5'd5, 4'd3);
    #1;
    vectors++; if (rd_dirty[0] !== 1'b0) begin miscompares++; $display("FAIL no_ds_forward: got %b want 0", rd_dirty[0]); end
    tick();
    vectors++; if (rd_dirty[0] !== 1'b1 || rd_tag[3:0] !== 4'd3) begin miscompares++; $display("FAIL renamed_x5: got %b/%0d want 1/3", rd_dirty[0], rd_tag[3:0]); end
    commit(5'd5, 4'd3, 32'hAB);
    #1;
    vectors++; if (rd_dirty[0] !== 1'b0 || rd_tag[3:0] !== 4'd0 || rd_val[31:0] !== 32'hAB) begin miscompares++; $display("FAIL bypass: got %b/%0d/%h want 0/0/ab", rd_dirty[0], rd_tag[3:0], rd_val[31:0]); end
    tick();
    vectors++; if (rd_dirty[0] !== 1'b0 || rd_tag[3:0] !== 4'd0 || rd_val[31:0] !== 32'hAB) begin miscompares++; $display("FAIL stored_x5: got %b/%0d/%h want 0/0/ab", rd_dirty[0], rd_tag[3:0], rd_val[31:0]); end
    vectors++; if (rd_dirty[1] !== 1'b0 || rd_val[63:32] !== 32'h0) begin miscompares++; $display("FAIL port1_x7: got %b/%h want 0/0", rd_dirty[1], rd_val[63:32]); end
  endtask

  task automatic test_rename_order();
    rd_idx = {5'd5, 5'd5};
    rename(5'd5, 4'd3); tick();
    rename(5'd5, 4'd7); tick();
    commit(5'd5, 4'd3, 32'h1);
    #1;
    vectors++; if (rd_dirty[1] !== 1'b1 || rd_tag[7:4] !== 4'd7 || rd_val[63:32] !== 32'hAB) begin miscompares++; $display("FAIL stale_no_bypass: got %b/%0d/%h want 1/7/ab", rd_dirty[1], rd_tag[7:4], rd_val[63:32]); end
    tick();
    vectors++; if (rd_dirty[0] !== 1'b1 || rd_tag[3:0] !== 4'd7 || rd_val[31:0] !== 32'h1) begin miscompares++; $display("FAIL stale_commit: got %b/%0d/%h want 1/7/1", rd_dirty[0], rd_tag[3:0], rd_val[31:0]); end
  endtask

  task automatic test_restore();
    rd_idx = {5'd5, 5'd6};
    rename(5'd6, 4'd2); tick();
    vectors++; if (ck_id !== 2'd0) begin miscompares++; $display("FAIL take_id: got %0d want 0", ck_id); end
    ck_take = 1'b1; tick();
    vectors++; if (ck_id !== 2'd1) begin miscompares++; $display("FAIL take_tail: got %0d want 1", ck_id); end
    rename(5'd6, 4'd5); tick();
    vectors++; if (rd_tag[3:0] !== 4'd5) begin miscompares++; $display("FAIL rename_after_take: got %0d want 5", rd_tag[3:0]); end
    ck_restore = 1'b1; ck_restore_id = 2'd0; rename(5'd6, 4'd9); tick();
    vectors++; if (rd_dirty[0] !== 1'b1 || rd_tag[3:0] !== 4'd2 || ck_id !== 2'd0) begin miscompares++; $display("FAIL restore_x6: got %b/%0d id %0d want 1/2 id 0", rd_dirty[0], rd_tag[3:0], ck_id); end
    vectors++; if (rd_dirty[1] !== 1'b1 || rd_tag[7:4] !== 4'd7) begin miscompares++; $display("FAIL restore_x5: got %b/%0d want 1/7", rd_dirty[1], rd_tag[7:4]); end
    ck_take = 1'b1; tick();
    rename(5'd6, 4'd5); tick();
    commit(5'd6, 4'd2, 32'h22); tick();
    vectors++; if (rd_dirty[0] !== 1'b1 || rd_tag[3:0] !== 4'd5) begin miscompares++; $display("FAIL live_not_cleared: got %b/%0d want 1/5", rd_dirty[0], rd_tag[3:0]); end
    ck_restore = 1'b1; ck_restore_id = 2'd0; tick();
    vectors++; if (rd_dirty[0] !== 1'b0 || rd_tag[3:0] !== 4'd0 || rd_val[31:0] !== 32'h22) begin miscompares++; $display("FAIL restore_clean: got %b/%0d/%h want 0/0/22", rd_dirty[0], rd_tag[3:0], rd_val[31:0]); end
  endtask

  task automatic test_full();
    flush = 1'b1; tick();
    for (int i = 1; i <= 4; i++) begin
      ck_take = 1'b1; tick();
      vectors++; if (ck_id !== 2'(i) || ck_full !== (i == 4)) begin miscompares++; $display("FAIL take_seq%0d: got id %0d full %b", i, ck_id, ck_full); end
    end
    ck_take = 1'b1; tick();
    vectors++; if (ck_id !== 2'd0 || ck_full !== 1'b1) begin miscompares++; $display("FAIL take_when_full: got id %0d full %b want 0 1", ck_id, ck_full); end
    ck_release = 1'b1; tick();
    vectors++; if (ck_full !== 1'b0 || ck_id !== 2'd0) begin miscompares++; $display("FAIL release: got full %b id %0d want 0 0", ck_full, ck_id); end
    ck_take = 1'b1; tick();
    vectors++; if (ck_id !== 2'd1 || ck_full !== 1'b1) begin miscompares++; $display("FAIL wrap_take: got id %0d full %b want 1 1", ck_id, ck_full); end
  endtask

  task automatic test_flush();
    ck_release = 1'b1; tick();
    for (int r = 10; r < 20; r++) begin
      rename(5'(r), 4'(r - 9)); tick();
    end
    rd_idx = {5'd9, 5'd10};
    rdy = 1'b0; flush = 1'b1; ck_take = 1'b1; ck_release = 1'b1; rename(5'd9, 4'd4); commit(5'd10, 4'd1, 32'h55);
    tick();
    vectors++; if (rd_dirty[0] !== 1'b1 || rd_tag[3:0] !== 4'd1 || rd_val[31:0] !== 32'h0) begin miscompares++; $display("FAIL frozen_x10: got %b/%0d/%h want 1/1/0", rd_dirty[0], rd_tag[3:0], rd_val[31:0]); end
    vectors++; if (rd_dirty[1] !== 1'b0 || ck_id !== 2'd1 || ck_full !== 1'b0) begin miscompares++; $display("FAIL frozen_ck: got x9 %b id %0d full %b want 0 1 0", rd_dirty[1], ck_id, ck_full); end
    flush = 1'b1; rename(5'd9, 4'd4); tick();
    vectors++; if (rd_dirty !== 2'b00 || rd_tag !== 8'h00 || ck_id !== 2'd0 || ck_full !== 1'b0) begin miscompares++; $display("FAIL flush: got dirty %b tag %h id %0d full %b", rd_dirty, rd_tag, ck_id, ck_full); end
    rd_idx = {5'd19, 5'd15};
    #1;
    vectors++; if (rd_dirty !== 2'b00) begin miscompares++; $display("FAIL flush_others: got %b want 00", rd_dirty); end
    ck_release = 1'b1; tick();
    for (int i = 1; i <= 4; i++) begin
      ck_take = 1'b1; tick();
    end
    vectors++; if (ck_full !== 1'b1 || ck_id !== 2'd0) begin miscompares++; $display("FAIL count_zero: got full %b id %0d want 1 0", ck_full, ck_id); end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_rename_order();
    test_restore();
    test_full();
    test_flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
